// File: rtl/data_bus_timer.sv
// Memory-mapped down-counting timer on the CPU data bus: CTRL/LOAD/COUNT/STATUS, W1C expiry, IRQ.
// Optional macro PRESCALER_EN adds a 16-bit PRESC register at offset 0x10 that divides the count tick.
module data_bus_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFF20_0100,
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic        oIRQ
);

`ifdef PRESCALER_EN
    localparam int unsigned AW = 5;
`else
    localparam int unsigned AW = 4;
`endif
    localparam int unsigned OW = AW - 2;

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           ar_q, ie_q, exp_q;
    logic [31:0]    load_q, count_q;
    logic           hit, wr, wr_ctrl, wr_load, wr_stat;
    logic [OW-1:0]  off;
    logic           en_req, ar_d, ie_d, tick;
    logic [31:0]    load_d;
    logic           start, step, expire;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    // Address decode; the two low address bits never participate
    assign hit     = (DwAddress[31:AW] == BASE_ADDR[31:AW]);
    assign off     = DwAddress[AW-1:2];
    assign wr      = DwWriteEnable && hit;
    assign wr_ctrl = wr && (off == OW'(0)) && DwByteEnable[0];
    assign wr_load = wr && (off == OW'(1));
    assign wr_stat = wr && (off == OW'(3)) && DwByteEnable[0] && DwWriteData[0];

    // Register values as they stand after this cycle's write
    assign en_req = wr_ctrl ? DwWriteData[0] : (state_q == RUNNING);
    assign ar_d   = wr_ctrl ? DwWriteData[1] : ar_q;
    assign ie_d   = wr_ctrl ? DwWriteData[2] : ie_q;
    assign load_d = wr_load ? lane_merge(load_q, DwWriteData, DwByteEnable) : load_q;

`ifdef PRESCALER_EN
    logic        wr_presc;
    logic [15:0] presc_q, pc_q;
    logic [31:0] presc_wr;
    logic        unused_bits;

    assign wr_presc    = wr && (off == OW'(4));
    assign presc_wr    = lane_merge({16'h0, presc_q}, DwWriteData, DwByteEnable);
    assign tick        = (pc_q == presc_q);
    assign unused_bits = ^{DwAddress[1:0], presc_wr[31:16]};

    // Tick divider: counts RUNNING cycles, restarts on every tick and on start
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            presc_q <= 16'h0;
            pc_q    <= 16'h0;
        end else begin
            if (wr_presc)
                presc_q <= presc_wr[15:0];
            if (start)
                pc_q <= 16'h0;
            else if ((state_q == RUNNING) && en_req)
                pc_q <= tick ? 16'h0 : pc_q + 16'd1;
        end
    end
`else
    logic unused_bits;
    assign tick        = 1'b1;
    assign unused_bits = ^DwAddress[1:0];
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= STOPPED;
        else      state_q <= state_d;
    end

    // Next state: software EN write, or one-shot expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            STOPPED: if (en_req) state_d = RUNNING;
            RUNNING: if (!en_req || (tick && (count_q == 32'd0) && !ar_d)) state_d = STOPPED;
            default: state_d = STOPPED;
        endcase
    end

    // Counter actions; an EN=0 write suppresses the tick at that edge
    always_comb begin
        start  = 1'b0;
        step   = 1'b0;
        expire = 1'b0;
        case (state_q)
            STOPPED: start = en_req;
            RUNNING: begin
                if (en_req && tick) begin
                    if (count_q == 32'd0) expire = 1'b1;
                    else                  step   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            exp_q   <= 1'b0;
            load_q  <= RESET_LOAD;
            count_q <= 32'h0;
        end else begin
            ar_q   <= ar_d;
            ie_q   <= ie_d;
            load_q <= load_d;
            if (start)
                count_q <= load_d;
            else if (step)
                count_q <= count_q - 32'd1;
            else if (expire && ar_d)
                count_q <= load_d;
            // Expiry beats a simultaneous W1C
            if (expire)
                exp_q <= 1'b1;
            else if (wr_stat)
                exp_q <= 1'b0;
        end
    end

    assign oIRQ = exp_q && ie_q;

    // Combinational read of pre-write values
    always_comb begin
        DwReadData = 32'h0;
        if (DwReadEnable && hit) begin
            case (off)
                OW'(0): DwReadData = {29'h0, ie_q, ar_q, state_q == RUNNING};
                OW'(1): DwReadData = load_q;
                OW'(2): DwReadData = count_q;
                OW'(3): DwReadData = {31'h0, exp_q};
`ifdef PRESCALER_EN
                OW'(4): DwReadData = {16'h0, presc_q};
`endif
                default: DwReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_timer.sv
// Bench for data_bus_timer: directed scenarios plus random bus traffic, all checked
// against a cycle-level behavioural model of the register/timer rules.
`timescale 1ns/1ps
module tb_data_bus_timer;
    localparam logic [31:0] BASE = 32'hFF20_0100;
`ifdef PRESCALER_EN
    localparam int unsigned AW = 5;
`else
    localparam int unsigned AW = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        irq;

    data_bus_timer #(.BASE_ADDR(BASE), .RESET_LOAD(32'h0)) dut (
        .iCLK(clk), .iRST(rst), .DwReadEnable(re), .DwWriteEnable(we),
        .DwByteEnable(be), .DwAddress(addr), .DwWriteData(wdata),
        .DwReadData(rdata), .oIRQ(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    bit          m_en, m_ar, m_ie, m_exp;
    int unsigned m_load, m_count, m_presc, m_pc;
    logic [31:0] last_rd;
    logic        last_irq;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_pc = 0;
    endtask

    function automatic int unsigned m_read(input logic [31:0] a);
        int unsigned o;
        if ((a >> AW) != (BASE >> AW)) return 0;
        o = (a % (32'd1 << AW)) / 4;
        case (o)
            0: return {29'd0, m_ie, m_ar, m_en};
            1: return m_load;
            2: return m_count;
            3: return {31'd0, m_exp};
`ifdef PRESCALER_EN
            4: return m_presc;
`endif
            default: return 0;
        endcase
    endfunction

    // One clock edge of the timer rules applied to this cycle's bus inputs
    task automatic model_step(input bit w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        bit hit, n_en, n_ar, n_ie, clr, set, tk;
        int unsigned o, n_load, n_presc;
        hit = (a >> AW) == (BASE >> AW);
        o = (a % (32'd1 << AW)) / 4;
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_load = m_load; n_presc = m_presc;
        clr = 0; set = 0; tk = 1;
        if (w && hit) begin
            if (o == 0 && b[0]) begin n_en = d[0]; n_ar = d[1]; n_ie = d[2]; end
            if (o == 1)
                for (int i = 0; i < 4; i++)
                    if (b[i]) n_load = (n_load & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
            if (o == 3 && b[0] && d[0]) clr = 1;
`ifdef PRESCALER_EN
            if (o == 4)
                for (int i = 0; i < 2; i++)
                    if (b[i]) n_presc = (n_presc & ~(32'hFF << (8*i))) | (d & (32'hFF << (8*i)));
`endif
        end
        if (!m_en && n_en) begin
            m_count = n_load;
            m_pc = 0;
        end else if (m_en && n_en) begin
`ifdef PRESCALER_EN
            tk = (m_pc == m_presc);
            m_pc = tk ? 0 : m_pc + 1;
`endif
            if (tk) begin
                if (m_count == 0) begin
                    set = 1;
                    if (n_ar) m_count = n_load;
                    else      n_en = 0;
                end else begin
                    m_count = m_count - 1;
                end
            end
        end
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_load = n_load; m_presc = n_presc;
        m_exp = set ? 1'b1 : (clr ? 1'b0 : m_exp);
    endtask

    // One bus cycle: drive at negedge, check read and IRQ, then advance the model at posedge
    task automatic cyc(input bit w, input bit r, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
        @(negedge clk);
        we = w; re = r; be = b; addr = a; wdata = d;
        #1;
        last_rd = rdata;
        last_irq = irq;
        check({tag, "_rd"}, rdata, r ? m_read(a) : 32'h0);
        check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_exp & m_ie});
        @(posedge clk);
        model_step(w, b, a, d);
    endtask

    task automatic wr(input logic [31:0] o, input logic [31:0] d);
        cyc(1, 0, 4'hF, BASE + o, d, "wr");
    endtask
    task automatic rd(input logic [31:0] o);
        cyc(0, 1, 4'h0, BASE + o, 32'h0, "rd");
    endtask
    task automatic idle();
        cyc(0, 0, 4'h0, 32'h0, 32'h0, "idle");
    endtask
    task automatic peek(input logic [31:0] o, input logic [31:0] exp, input string tag);
        re = 1; we = 0; addr = BASE + o;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1; re = 0; we = 0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        model_reset();
        peek(32'h0, 32'h0, "rst_ctrl");
        peek(32'h4, 32'h0, "rst_load");
        peek(32'h8, 32'h0, "rst_count");
        peek(32'hC, 32'h0, "rst_status");
        check("rst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        rst = 0;

        // One-shot count 3,2,1,0 then expiry and self-stop
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h1);
        for (int k = 0; k < 4; k++) begin
            rd(32'h8);
            check("oneshot_count", last_rd, 32'(3 - k));
        end
        rd(32'hC);
        check("oneshot_exp", last_rd, 32'h1);
        rd(32'h0);
        check("oneshot_ctrl", last_rd, 32'h0);
        wr(32'hC, 32'h1);

        // Auto-reload with IRQ, then W1C away from expiry
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h7);
        for (int k = 0; k < 6; k++) begin
            rd(32'h8);
            check("reload_count", last_rd, 32'(2 - (k % 3)));
        end
        rd(32'h8);
        wr(32'hC, 32'h1);
        rd(32'hC);
        check("w1c_irq", {31'd0, last_irq}, 32'h0);
        wr(32'h0, 32'h0);
        wr(32'hC, 32'h1);

        // W1C in the expiry cycle loses to the set
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h3);
        idle();
        wr(32'hC, 32'h1);
        rd(32'hC);
        check("w1c_vs_exp", last_rd, 32'h1);
        wr(32'h0, 32'h0);
        wr(32'hC, 32'h1);

        // Stop at COUNT=5 holds the count with no expiry
        wr(32'h4, 32'd8);
        wr(32'h0, 32'h1);
        repeat (3) idle();
        wr(32'h0, 32'h0);
        rd(32'h8);
        check("stop_hold", last_rd, 32'd5);
        rd(32'hC);
        check("stop_noexp", last_rd, 32'h0);

        // Byte lanes, out-of-window read, read-during-write
        wr(32'h4, 32'h0);
        cyc(1, 0, 4'b0100, BASE + 32'h4, 32'hAABB_CCDD, "lane");
        rd(32'h4);
        check("lane_load", last_rd, 32'h00BB_0000);
        rd(32'h40);
        check("outside", last_rd, 32'h0);
        cyc(1, 1, 4'hF, BASE + 32'h4, 32'h1234_5678, "rdwr");
        check("rdwr_old", last_rd, 32'h00BB_0000);
        rd(32'h4);
        check("rdwr_new", last_rd, 32'h1234_5678);

`ifdef PRESCALER_EN
        wr(32'h10, 32'h1);
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        repeat (5) idle();
        rd(32'hC);
        check("presc_early", last_rd, 32'h0);
        rd(32'hC);
        check("presc_exp", last_rd, 32'h1);
        wr(32'h0, 32'h0);
        wr(32'hC, 32'h1);
        wr(32'h10, 32'h0);
`endif

        // Random bus traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  rb;
            logic [31:0] ra, rdat;
            rb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            ra = BASE + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) ra = $urandom;
            rdat = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 7));
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, rb, ra, rdat, "rand");
        end

        // Asynchronous reset mid-count
        wr(32'h0, 32'h0);
        wr(32'h4, 32'd20);
        wr(32'h0, 32'h5);
        for (int i = 0; i < 40 && m_count != 7; i++) idle();
        @(negedge clk);
        peek(32'h8, 32'd7, "pre_rst_count");
        rst = 1;
        model_reset();
        peek(32'h0, 32'h0, "arst_ctrl");
        peek(32'h4, 32'h0, "arst_load");
        peek(32'h8, 32'h0, "arst_count");
        peek(32'hC, 32'h0, "arst_status");
        check("arst_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        rst = 0;
        repeat (30) idle();
        rd(32'hC);
        check("post_rst_exp", last_rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
